hd_dma_engine: RTL and testbench

- Block-copy engine sitting directly beside the hard-disk store; drives its addr/data/write inputs and consumes its data_HD output.
- Moves a programmed number of 32-bit words between the hard disk and the data memory in either direction, one word per clock after a 1-cycle fill.
- Used by the boot loader path (disk -> memory) and by the store path (memory -> disk); the CPU starts it and polls busy/done.

---
 rtl/hd_dma_engine_if.sv | 34 +++
 rtl/hd_dma_engine.sv | 134 +++++++++++++
 tb/tb_hd_dma_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hd_dma_engine_if.sv
// rtl/hd_dma_engine_if.sv - Control, status and disk/memory bus bundle for hd_dma_engine
interface hd_dma_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 14
);
  logic                  start;
  logic                  dir;
  logic [DATA_WIDTH-1:0] hd_base;
  logic [DATA_WIDTH-1:0] mem_base;
  logic [LEN_WIDTH-1:0]  length;
  logic [DATA_WIDTH-1:0] hd_addr;
  logic [DATA_WIDTH-1:0] hd_wdata;
  logic                  hd_write;
  logic [DATA_WIDTH-1:0] hd_rdata;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    input  start, dir, hd_base, mem_base, length, hd_rdata, mem_rdata,
    output hd_addr, hd_wdata, hd_write, mem_addr, mem_wdata, mem_write,
           busy, done, checksum
  );

  modport slave (
    output start, dir, hd_base, mem_base, length, hd_rdata, mem_rdata,
    input  hd_addr, hd_wdata, hd_write, mem_addr, mem_wdata, mem_write,
           busy, done, checksum
  );
endinterface

// File: rtl/hd_dma_engine.sv
// rtl/hd_dma_engine.sv - Block copy between hard disk and data memory, one word per clock
// Optional running sum of written words in checksum: define HD_DMA_CHECKSUM_EN.
module hd_dma_engine #(
  parameter int DATA_WIDTH    = 32,
  parameter int HD_ADDR_WIDTH = 13,
  parameter int LEN_WIDTH     = 14
) (
  input logic             clock,
  input logic             reset,
  hd_dma_engine_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] HD_MASK =
    (DATA_WIDTH'(1) << HD_ADDR_WIDTH) - DATA_WIDTH'(1);

  state_t                state;
  logic                  dir_q;
  logic [DATA_WIDTH-1:0] hd_base_q;
  logic [DATA_WIDTH-1:0] mem_base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] hd_addr_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic                  hd_write_q;
  logic                  mem_write_q;
  logic                  busy_q;
  logic                  done_q;

  logic [LEN_WIDTH-1:0]  count_nxt;
  logic [DATA_WIDTH-1:0] cnt_w;
  logic [DATA_WIDTH-1:0] cnt_nxt_w;
  logic                  more_reads;

  assign count_nxt  = count + 1'b1;
  assign cnt_w      = DATA_WIDTH'(count);
  assign cnt_nxt_w  = DATA_WIDTH'(count_nxt);
  assign more_reads = (count_nxt != len_q);

  // Outputs are set at the edge entering a cycle: RUN cycle c reads word c and writes word c-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dir_q       <= 1'b0;
      hd_base_q   <= '0;
      mem_base_q  <= '0;
      len_q       <= '0;
      count       <= '0;
      hd_addr_q   <= '0;
      mem_addr_q  <= '0;
      hd_write_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      hd_addr_q   <= '0;
      mem_addr_q  <= '0;
      hd_write_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dir_q      <= bus.dir;
            hd_base_q  <= bus.hd_base;
            mem_base_q <= bus.mem_base;
            len_q      <= bus.length;
            count      <= '0;
            if (bus.length != '0) begin
              state  <= RUN;
              busy_q <= 1'b1;
              if (bus.dir) mem_addr_q <= bus.mem_base;
              else         hd_addr_q  <= bus.hd_base & HD_MASK;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          busy_q <= 1'b1;
          count  <= count_nxt;
          if (dir_q) begin
            hd_write_q <= 1'b1;
            hd_addr_q  <= (hd_base_q + cnt_w) & HD_MASK;
            if (more_reads) mem_addr_q <= mem_base_q + cnt_nxt_w;
          end else begin
            mem_write_q <= 1'b1;
            mem_addr_q  <= mem_base_q + cnt_w;
            if (more_reads) hd_addr_q <= (hd_base_q + cnt_nxt_w) & HD_MASK;
          end
          if (!more_reads) state <= DRAIN;
        end
        DRAIN: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives in the write cycle, so write data is forwarded straight from the source.
  assign bus.hd_wdata  = hd_write_q  ? bus.mem_rdata : '0;
  assign bus.mem_wdata = mem_write_q ? bus.hd_rdata  : '0;
  assign bus.hd_addr   = hd_addr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.hd_write  = hd_write_q;
  assign bus.mem_write = mem_write_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef HD_DMA_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else if (state == IDLE && bus.start) begin
      checksum_q <= '0;
    end else if (hd_write_q) begin
      checksum_q <= checksum_q + bus.mem_rdata;
    end else if (mem_write_q) begin
      checksum_q <= checksum_q + bus.hd_rdata;
    end
  end

  assign bus.checksum = checksum_q;
`else
  assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_hd_dma_engine.sv
// tb/tb_hd_dma_engine.sv - Randomized self-checking bench for hd_dma_engine against a cycle-level model
module tb_hd_dma_engine;
  localparam int          DW        = 32;
  localparam int          LW        = 14;
  localparam int          MEM_WORDS = 4096;
  localparam logic [31:0] HD_MASK   = 32'h0000_1FFF;
  localparam logic [31:0] SENT      = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hd_dma_engine_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  hd_dma_engine #(.DATA_WIDTH(DW), .HD_ADDR_WIDTH(13), .LEN_WIDTH(LW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Disk and data memory: registered read address, one cycle read latency.
  logic [31:0] disk [8192];
  logic [31:0] memw [MEM_WORDS];

  always @(posedge clock) begin
    bus.hd_rdata  <= disk[bus.hd_addr[12:0]];
    bus.mem_rdata <= memw[bus.mem_addr[11:0]];
    if (bus.hd_write)  disk[bus.hd_addr[12:0]]  = bus.hd_wdata;
    if (bus.mem_write) memw[bus.mem_addr[11:0]] = bus.mem_wdata;
  end

  // Reference model: a transfer accepted at edge t_start occupies cycles k = 1 .. k_end.
  int          cyc = 0;
  bit          active = 1'b0;
  int          t_start = 0;
  int          k_end = 0;
  bit          m_dir;
  logic [31:0] m_hb, m_mb;
  int          m_len = 0;
  logic [31:0] snap [$];

  always @(posedge clock) begin
    cyc++;
    if (reset && bus.start && (!active || cyc > t_start + k_end)) begin
      active  = 1'b1;
      t_start = cyc;
      m_dir   = bus.dir;
      m_hb    = bus.hd_base;
      m_mb    = bus.mem_base;
      m_len   = int'(bus.length);
      k_end   = (m_len == 0) ? 1 : m_len + 2;
      snap.delete();
      for (int i = 0; i < m_len; i++)
        snap.push_back(bus.dir ? memw[(bus.mem_base + 32'(i)) & 32'(MEM_WORDS - 1)]
                               : disk[(bus.hd_base + 32'(i)) & HD_MASK]);
    end
  end

  always @(negedge clock) begin
    logic [31:0] e_ha, e_hw_d, e_ma, e_mw_d, e_ck;
    logic        e_hw, e_mw, e_busy, e_done;
    int          k, n;
    e_ha = '0; e_hw_d = '0; e_ma = '0; e_mw_d = '0; e_ck = '0;
    e_hw = 1'b0; e_mw = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    k = cyc - t_start + 1;
    if (reset && active && k <= k_end) begin
      e_busy = (m_len > 0) && (k <= m_len + 1);
      e_done = (k == k_end);
      if (!m_dir) begin
        if (k <= m_len) e_ha = (m_hb + 32'(k - 1)) & HD_MASK;
        e_mw = (k >= 2) && (k <= m_len + 1);
        if (e_mw) begin
          e_ma   = m_mb + 32'(k - 2);
          e_mw_d = snap[k-2];
        end
      end else begin
        if (k <= m_len) e_ma = m_mb + 32'(k - 1);
        e_hw = (k >= 2) && (k <= m_len + 1);
        if (e_hw) begin
          e_ha   = (m_hb + 32'(k - 2)) & HD_MASK;
          e_hw_d = snap[k-2];
        end
      end
    end
`ifdef HD_DMA_CHECKSUM_EN
    if (reset && active) begin
      n = k - 2;
      if (n < 0) n = 0;
      if (n > m_len) n = m_len;
      for (int i = 0; i < n; i++) e_ck = e_ck + snap[i];
    end
`endif
    check("hd_addr",   bus.hd_addr,   e_ha);
    check("hd_wdata",  bus.hd_wdata,  e_hw_d);
    check("hd_write",  32'(bus.hd_write),  32'(e_hw));
    check("mem_addr",  bus.mem_addr,  e_ma);
    check("mem_wdata", bus.mem_wdata, e_mw_d);
    check("mem_write", 32'(bus.mem_write), 32'(e_mw));
    check("busy",      32'(bus.busy), 32'(e_busy));
    check("done",      32'(bus.done), 32'(e_done));
    check("checksum",  bus.checksum,  e_ck);
  end

  task automatic run_xfer(input bit d, input logic [31:0] hb, input logic [31:0] mb, input int len,
                          input bit repulse, output int done_k, output int busy_cnt, output int done_cnt);
    @(negedge clock);
    bus.start    = 1'b1;
    bus.dir      = d;
    bus.hd_base  = hb;
    bus.mem_base = mb;
    bus.length   = LW'(len);
    done_k = -1; busy_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= len + 8; k++) begin
      @(negedge clock);
      if (k == 1) begin
        bus.start    = 1'b0;
        bus.dir      = 1'($urandom);
        bus.hd_base  = $urandom;
        bus.mem_base = $urandom;
        bus.length   = LW'($urandom);
      end
      if (repulse && k == 3) begin
        bus.start   = 1'b1;
        bus.hd_base = hb + 32'd100;
        bus.dir     = d;
        bus.length  = LW'(len);
      end
      if (repulse && k == 4) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
    end
  endtask

  initial begin
    int dk, bc, dc, len;
    bit d;
    logic [31:0] hb, mb;
    reset = 1'b0;
    bus.start = 1'b0; bus.dir = 1'b0; bus.hd_base = '0; bus.mem_base = '0; bus.length = '0;
    for (int i = 0; i < 8192; i++) disk[i] = 32'(i) ^ 32'h5A00_0000;
    for (int i = 0; i < MEM_WORDS; i++) memw[i] = '0;
    repeat (3) @(negedge clock);
    check("rst_busy",     32'(bus.busy), 0);
    check("rst_done",     32'(bus.done), 0);
    check("rst_hd_addr",  bus.hd_addr, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_checksum", bus.checksum, 0);
    reset = 1'b1;

    // Load 4 words from disk 16 to memory 256.
    disk[16] = 32'hA000_000A; disk[17] = 32'hB000_000B; disk[18] = 32'hC000_000C; disk[19] = 32'hD000_000D;
    run_xfer(1'b0, 32'd16, 32'd256, 4, 1'b0, dk, bc, dc);
    check("t1_done_k", 32'(dk), 32'd6);
    check("t1_busy_n", 32'(bc), 32'd5);
    check("t1_done_n", 32'(dc), 32'd1);
    check("t1_mem256", memw[256], 32'hA000_000A);
    check("t1_mem257", memw[257], 32'hB000_000B);
    check("t1_mem258", memw[258], 32'hC000_000C);
    check("t1_mem259", memw[259], 32'hD000_000D);

    // Store 3 words across the disk wrap.
    memw[0] = 32'd1; memw[1] = 32'd2; memw[2] = 32'd3;
    disk[8190] = SENT; disk[8191] = SENT; disk[0] = SENT;
    run_xfer(1'b1, 32'd8190, 32'd0, 3, 1'b0, dk, bc, dc);
    check("t2_done_k",  32'(dk), 32'd5);
    check("t2_disk8190", disk[8190], 32'd1);
    check("t2_disk8191", disk[8191], 32'd2);
    check("t2_disk0",    disk[0],    32'd3);

    // Zero length.
    run_xfer(1'b0, 32'd5, 32'd5, 0, 1'b0, dk, bc, dc);
    check("t3_done_k", 32'(dk), 32'd1);
    check("t3_busy_n", 32'(bc), 32'd0);
    check("t3_done_n", 32'(dc), 32'd1);

    // Restart attempt during RUN is ignored.
    for (int i = 0; i < 8; i++) begin
      disk[100 + i] = 32'h1100_0000 + 32'(i);
      disk[200 + i] = 32'h2200_0000 + 32'(i);
    end
    run_xfer(1'b0, 32'd100, 32'd512, 8, 1'b1, dk, bc, dc);
    check("t4_done_n", 32'(dc), 32'd1);
    check("t4_done_k", 32'(dk), 32'd10);
    for (int i = 0; i < 8; i++) check("t4_word", memw[512 + i], 32'h1100_0000 + 32'(i));

    // Reset during RUN after two words have landed.
    for (int i = 0; i < 5; i++) memw[700 + i] = SENT;
    @(negedge clock);
    bus.start = 1'b1; bus.dir = 1'b0; bus.hd_base = 32'd300; bus.mem_base = 32'd700; bus.length = LW'(5);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    reset  = 1'b0;
    active = 1'b0;
    #1;
    check("t5_busy",      32'(bus.busy), 0);
    check("t5_hd_addr",   bus.hd_addr, 0);
    check("t5_mem_addr",  bus.mem_addr, 0);
    check("t5_mem_write", 32'(bus.mem_write), 0);
    check("t5_mem_wdata", bus.mem_wdata, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    check("t5_w0", memw[700], disk[300]);
    check("t5_w1", memw[701], disk[301]);
    for (int i = 2; i < 5; i++) check("t5_untouched", memw[700 + i], SENT);
    run_xfer(1'b0, 32'd300, 32'd700, 5, 1'b0, dk, bc, dc);
    check("t5_redo_k", 32'(dk), 32'd7);
    for (int i = 0; i < 5; i++) check("t5_redo", memw[700 + i], disk[300 + i]);

    // Checksum wraps.
    disk[40] = 32'hFFFF_FFFF; disk[41] = 32'h0000_0002;
    run_xfer(1'b0, 32'd40, 32'd900, 2, 1'b0, dk, bc, dc);
`ifdef HD_DMA_CHECKSUM_EN
    check("t6_checksum", bus.checksum, 32'h0000_0001);
`else
    check("t6_checksum", bus.checksum, 32'h0000_0000);
`endif

    // Randomized transfers in both directions.
    for (int t = 0; t < 25; t++) begin
      d   = 1'($urandom);
      len = $urandom_range(0, 40);
      hb  = $urandom;
      mb  = $urandom;
      if (t == 0) mb = 32'hFFFF_FFF0;
      for (int i = 0; i < len; i++) begin
        if (d) memw[(mb + 32'(i)) & 32'(MEM_WORDS - 1)] = $urandom;
        else   disk[(hb + 32'(i)) & HD_MASK] = $urandom;
      end
      run_xfer(d, hb, mb, len, 1'b0, dk, bc, dc);
      check("rnd_done_k", 32'(dk), (len == 0) ? 32'd1 : 32'(len + 2));
      check("rnd_done_n", 32'(dc), 32'd1);
      check("rnd_busy_n", 32'(bc), (len == 0) ? 32'd0 : 32'(len + 1));
      for (int i = 0; i < len; i++) begin
        if (d) check("rnd_disk", disk[(hb + 32'(i)) & HD_MASK], snap[i]);
        else   check("rnd_mem",  memw[(mb + 32'(i)) & 32'(MEM_WORDS - 1)], snap[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
